// File: rtl/pfpu_fdiv_pkg.sv
// pfpu_fdiv_pkg: shared PFPU divider constants and types.
// The scheduler and the divider both read the iteration count and the
// fixed result latency from here so they can never disagree.
`timescale 1ns/1ps
package pfpu_fdiv_pkg;

  // Restoring-division iterations (one quotient bit per DIV cycle).
  localparam int PFPU_FDIV_ITERS   = 25;
  // Cycles from accepted valid_i to valid_o: DIV iterations + NORM + output reg.
  localparam int PFPU_FDIV_LATENCY = PFPU_FDIV_ITERS + 2;

  localparam int MANT_W = 24;               // mantissa with hidden 1
  localparam int QUO_W  = PFPU_FDIV_ITERS;  // quotient bits produced
  localparam int CNT_W  = $clog2(PFPU_FDIV_ITERS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_NORM = 2'd2
  } fdiv_state_e;

endpackage

// File: rtl/pfpu_fdiv_mant.sv
// pfpu_fdiv_mant: restoring mantissa divider, one quotient bit per cycle.
// Ports:
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   start_i         : load {1,frac_a_i} / {1,frac_b_i} and begin iterating
//   frac_a_i/_b_i   : 23-bit fractions of dividend / divisor
//   q_o             : quotient, valid the cycle after last_o
//   last_o          : high during the cycle whose edge computes the final bit
`timescale 1ns/1ps
module pfpu_fdiv_mant
  import pfpu_fdiv_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [22:0]       frac_a_i,
  input  logic [22:0]       frac_b_i,
  output logic [QUO_W-1:0]  q_o,
  output logic              last_o
);

  logic [MANT_W:0]   rem_q, rem_d;   // one guard bit: rem < 2*divisor always
  logic [MANT_W-1:0] div_q;
  logic [QUO_W-1:0]  quo_q, quo_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              active_q;
  logic              ge;
  logic [MANT_W:0]   rem_sub;

  always_comb begin
    ge      = (rem_q >= {1'b0, div_q});
    rem_sub = ge ? (rem_q - {1'b0, div_q}) : rem_q;
    // After a conditional subtract rem < divisor < 2^24, so the shift never overflows.
    rem_d   = {rem_sub[MANT_W-1:0], 1'b0};
    quo_d   = {quo_q[QUO_W-2:0], ge};
  end

  assign last_o = active_q && (cnt_q == CNT_W'(PFPU_FDIV_ITERS - 1));
  assign q_o    = quo_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rem_q    <= '0;
      div_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else if (start_i) begin
      rem_q    <= {2'b01, frac_a_i};
      div_q    <= {1'b1, frac_b_i};
      quo_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b1;
    end else if (active_q) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      cnt_q <= cnt_q + 1'b1;
      if (last_o) active_q <= 1'b0;
    end
  end

endmodule

// File: rtl/pfpu_fdiv.sv
// pfpu_fdiv: PFPU float divider, fixed 27-cycle latency, one op in flight.
// Ports:
//   sys_clk   : clock
//   alu_rst_n : asynchronous active-low reset
//   a, b      : dividend / divisor (sign, 8-bit exp, 23-bit fraction)
//   valid_i   : operands valid; accepted only when not busy
//   r         : registered quotient, held between results
//   valid_o   : one-cycle pulse when r updates
//   busy      : operation in flight, valid_i ignored
`timescale 1ns/1ps
module pfpu_fdiv
  import pfpu_fdiv_pkg::*;
(
  input  logic        sys_clk,
  input  logic        alu_rst_n,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        valid_i,
  output logic [31:0] r,
  output logic        valid_o,
  output logic        busy
);

  fdiv_state_e      state_q;
  logic             sign_q;
  logic [7:0]       exp_q;
  logic             a_zero_q;
  logic             b_zero_q;
  logic             start;
  logic [QUO_W-1:0] quo;
  logic             mant_last;
  logic [31:0]      result_d;

  assign start = (state_q == ST_IDLE) && valid_i;

  pfpu_fdiv_mant u_mant (
    .clk_i    (sys_clk),
    .rst_ni   (alu_rst_n),
    .start_i  (start),
    .frac_a_i (a[22:0]),
    .frac_b_i (b[22:0]),
    .q_o      (quo),
    .last_o   (mant_last)
  );

  // Zero dividend wins over divide-by-zero; otherwise normalise by one bit
  // at most, since the mantissa ratio lies in (0.5, 2).
  always_comb begin
    result_d = {sign_q, 31'd0};
    if (a_zero_q) begin
      result_d = {sign_q, 31'd0};
    end else if (b_zero_q) begin
      result_d = {sign_q, 8'hFF, 23'd0};
    end else if (quo[QUO_W-1]) begin
      result_d = {sign_q, exp_q, quo[23:1]};
    end else begin
      result_d = {sign_q, exp_q - 8'd1, quo[22:0]};
    end
  end

  always_ff @(posedge sys_clk or negedge alu_rst_n) begin
    if (!alu_rst_n) begin
      state_q  <= ST_IDLE;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      a_zero_q <= 1'b0;
      b_zero_q <= 1'b0;
      r        <= '0;
      valid_o  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (valid_i) begin
            sign_q   <= a[31] ^ b[31];
            exp_q    <= a[30:23] - b[30:23] + 8'd127;
            a_zero_q <= (a[30:23] == 8'd0);
            b_zero_q <= (b[30:23] == 8'd0);
            busy     <= 1'b1;
            state_q  <= ST_DIV;
          end
        end
        ST_DIV: begin
          if (mant_last) state_q <= ST_NORM;
        end
        ST_NORM: begin
          r       <= result_d;
          valid_o <= 1'b1;
          busy    <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/pfpu_fdiv.md
PFPU_FDIV -- requirements
Module: pfpu_fdiv

Interface
REQ-001 SHALL have port sys_clk, input, 1 bit: the only clock; all state changes on its rising edge.
REQ-002 SHALL have port alu_rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have port a, input, 32 bits: dividend in PFPU float format (sign, 8-bit exponent, 23-bit fraction, hidden 1).
REQ-004 SHALL have port b, input, 32 bits: divisor, same format.
REQ-005 SHALL have port valid_i, input, 1 bit: a and b are valid this cycle.
REQ-006 SHALL have port r, output, 32 bits, registered: quotient a/b.
REQ-007 SHALL have port valid_o, output, 1 bit, registered: one-cycle pulse when r carries a new result.
REQ-008 SHALL have port busy, output, 1 bit, registered: an operation is in flight and valid_i is ignored.

Function
REQ-009 SHALL accept an operation on a rising edge with valid_i=1 and busy=0, latching a, b, sign=a[31]^b[31], and exp=a[30:23]-b[30:23]+127 (mod 256).
REQ-010 SHALL ignore valid_i while busy=1; the operation in flight continues undisturbed and the dropped operation produces no result.
REQ-011 SHALL use states IDLE -> DIV (exactly 25 cycles) -> NORM (1 cycle) -> IDLE, with busy=1 in DIV and NORM.
REQ-012 SHALL have a fixed latency, zero/divide-by-zero operands included: valid_o is high exactly 27 cycles after the cycle in which valid_i was accepted.
REQ-013 SHALL deassert busy in the same cycle valid_o is high, so that a valid_i in that cycle is accepted (back-to-back throughput of one result per 27 cycles).
REQ-014 SHALL perform restoring division of mantissa {1,a[22:0]} by {1,b[22:0]}, with a 25-bit remainder initialised to the dividend; each DIV cycle sets q bit = (rem>=divisor), subtracts the divisor if set, then shifts rem left by 1, producing q[24:0] MSB first.
REQ-015 SHALL normalise in NORM: if q[24]=1, fraction=q[23:1] and exponent=exp; else fraction=q[22:0] and exponent=exp-1 (mod 256); no rounding (truncate).
REQ-016 SHALL produce {sign,8'd0,23'd0} when the exponent of a is 0 (zero dividend), with precedence over REQ-017.
REQ-017 SHALL produce {sign,8'd255,23'd0} when the exponent of b is 0 and the exponent of a is nonzero (divide by zero).
REQ-018 SHALL NOT detect exponent overflow/underflow, denormals, inf or NaN; exponent wraps modulo 256.
REQ-019 SHALL hold r stable between results.

Reset
REQ-020 SHALL, while alu_rst_n=0, force r=0, valid_o=0, busy=0 and state=IDLE, and clear the remainder, quotient and iteration counter.
REQ-021 SHALL, on reset mid-operation, abort the operation with no valid_o pulse; the first valid_i after release is accepted normally.

Structure
REQ-022 SHALL take the iteration count (25) and latency (27) from the shared PFPU header constants, so that the PFPU scheduler uses the same values.
REQ-023 SHALL put the mantissa restoring-division datapath (remainder, quotient and counter) in one sub-module, pfpu_fdiv_mant; the FSM, exponent/sign logic and special cases stay in pfpu_fdiv.

Verification
REQ-024 SHALL check a=0x40C00000 (6.0), b=0x40000000 (2.0) -> r=0x40400000, with valid_o 27 cycles after valid_i.
REQ-025 SHALL check a=0x3F800000, b=0x40400000 (1/3) -> r=0x3EAAAAAA (truncated).
REQ-026 SHALL check a=0xC1000000 (-8.0), b=0x3F000000 (0.5) -> r=0xC1800000; and a=0x3F800000, b=0x00000000 -> r=0x7F800000 at the same latency.
REQ-027 SHALL check that valid_i pulsed at cycles 0 and 10 yields exactly one valid_o, at cycle 27, and that valid_i at cycle 27 is accepted with its result at cycle 54.
REQ-028 SHALL check that alu_rst_n low at cycle 12 of an operation gives no valid_o, r=0, busy=0, and that a new operation completes correctly after release.
